// File: rtl/bsg_idiv_unsigned_recip_cfg_gen_if.sv
// Handshake bundle between a divisor producer and the
// reciprocal config generator.
interface bsg_idiv_unsigned_recip_cfg_gen_if #(
  parameter int denom_width_p    = 8,
  parameter int shift_width_p    = $clog2(denom_width_p+1),
  parameter int multiply_width_p = 9
);
  logic                        v_i;
  logic [denom_width_p-1:0]    denom_i;
  logic                        ready_o;
  logic                        v_o;
  logic [multiply_width_p-1:0] cfg_multiply_o;
  logic [shift_width_p-1:0]    cfg_shift_o;
  logic                        err_o;
  logic                        yumi_i;

  modport master (
    output v_i, denom_i, yumi_i,
    input  ready_o, v_o, cfg_multiply_o,
    input  cfg_shift_o, err_o
  );

  modport slave (
    input  v_i, denom_i, yumi_i,
    output ready_o, v_o, cfg_multiply_o,
    output cfg_shift_o, err_o
  );
endinterface

// File: rtl/bsg_idiv_unsigned_recip_cfg_gen.sv
// Computes (multiply, shift) for a reciprocal divider from a
// divisor using a bit-serial restoring division.
module bsg_idiv_unsigned_recip_cfg_gen #(
  parameter int numer_width_p    = 8,
  parameter int denom_width_p    = 8,
  parameter int shift_width_p    = $clog2(denom_width_p+1),
  parameter int multiply_width_p = numer_width_p+1
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_idiv_unsigned_recip_cfg_gen_if.slave io
);

  localparam int cnt_width_lp = $clog2(numer_width_p+2);
  localparam int q_width_lp   = numer_width_p+1;
  localparam int r_width_lp   = denom_width_p+1;

  if (denom_width_p < 1 || denom_width_p > numer_width_p) begin : g_bad
    $error("illegal denom_width_p");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e state_r, state_n;

  logic [denom_width_p-1:0]    den_r;
  logic [r_width_lp-1:0]       rem_r;
  logic [q_width_lp-1:0]       dq_r;
  logic [cnt_width_lp-1:0]     cnt_r;
  logic [shift_width_p-1:0]    sh_r;
  logic [multiply_width_p-1:0] mult_r;
  logic [shift_width_p-1:0]    shift_r;
  logic                        err_r;

  logic                        den_zero;
  logic [denom_width_p-1:0]    den_m1;
  logic [shift_width_p-1:0]    shift_n;
  logic [r_width_lp-1:0]       rem_init;
  logic [q_width_lp-1:0]       dq_init;
  logic [r_width_lp-1:0]       trial;
  logic [r_width_lp-1:0]       diff;
  logic                        ge;
  logic [q_width_lp-1:0]       q_next;
  logic                        last;

  assign den_zero = (io.denom_i == '0);
  assign den_m1   = io.denom_i - denom_width_p'(1);

  // shift is the bit-length of (divisor-1)
  always_comb begin
    shift_n = '0;
    for (int i = 0; i < denom_width_p; i++) begin
      if (den_m1[i]) shift_n = shift_width_p'(i+1);
    end
  end

  // Dividend 2^(s+N)+d-1 splits into a high part 2^(s-1)
  // (already < d) and low N+1 bits d-1; s=0 is the d=1 case.
  always_comb begin
    rem_init = '0;
    dq_init  = '0;
    if (shift_n == '0) begin
      dq_init[q_width_lp-1] = 1'b1;
    end else begin
      rem_init = r_width_lp'(1) << (shift_n - shift_width_p'(1));
      dq_init  = q_width_lp'(den_m1);
    end
  end

  assign trial  = (rem_r << 1) | r_width_lp'(dq_r[q_width_lp-1]);
  assign ge     = (trial >= {1'b0, den_r});
  assign diff   = trial - {1'b0, den_r};
  assign q_next = {dq_r[q_width_lp-2:0], ge};
  assign last   = (cnt_r == cnt_width_lp'(numer_width_p));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      IDLE: if (io.v_i) state_n = den_zero ? DONE : CALC;
      CALC: if (last) state_n = DONE;
      DONE: if (io.yumi_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      den_r   <= '0;
      rem_r   <= '0;
      dq_r    <= '0;
      cnt_r   <= '0;
      sh_r    <= '0;
      mult_r  <= '0;
      shift_r <= '0;
      err_r   <= 1'b0;
    end else begin
      unique case (state_r)
        IDLE: begin
          if (io.v_i) begin
            den_r <= io.denom_i;
            cnt_r <= '0;
            if (den_zero) begin
              mult_r  <= '0;
              shift_r <= '0;
              err_r   <= 1'b1;
            end else begin
              sh_r  <= shift_n;
              rem_r <= rem_init;
              dq_r  <= dq_init;
            end
          end
        end
        CALC: begin
          rem_r <= ge ? diff : trial;
          dq_r  <= q_next;
          cnt_r <= last ? '0 : cnt_r + cnt_width_lp'(1);
          if (last) begin
            mult_r  <= multiply_width_p'(q_next);
            shift_r <= sh_r;
            err_r   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.ready_o        = (state_r == IDLE);
  assign io.v_o            = (state_r == DONE);
  assign io.cfg_multiply_o = mult_r;
  assign io.cfg_shift_o    = shift_r;
  assign io.err_o          = err_r;

endmodule

// File: tb/tb_bsg_idiv_unsigned_recip_cfg_gen.sv
// Directed checks of the reciprocal config generator, chained
// into a behavioural reciprocal divider for all divisors.
module tb_bsg_idiv_unsigned_recip_cfg_gen;
  localparam int N = 8;
  localparam int W = 8;
  localparam int S = $clog2(W+1);
  localparam int M = N+1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bsg_idiv_unsigned_recip_cfg_gen_if #(
    .denom_width_p(W), .shift_width_p(S), .multiply_width_p(M)
  ) io ();

  bsg_idiv_unsigned_recip_cfg_gen #(
    .numer_width_p(N), .denom_width_p(W),
    .shift_width_p(S), .multiply_width_p(M)
  ) u_dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .io(io.slave)
  );

  task automatic check(input string tag, input longint obs,
                       input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic run_div(input logic [W-1:0] d, output int lat);
    @(negedge clk);
    io.v_i = 1'b1;
    io.denom_i = d;
    @(posedge clk);
    #1;
    io.v_i = 1'b0;
    lat = 1;
    while (!io.v_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    io.yumi_i = 1'b1;
    @(posedge clk);
    #1;
    io.yumi_i = 1'b0;
    check("ready_after_yumi", io.ready_o, 1);
    check("v_after_yumi", io.v_o, 0);
  endtask

  task automatic div_case(input string tag, input int d,
                          input int lat_e, input int sh_e,
                          input int mul_e, input int err_e);
    int lat;
    run_div(W'(d), lat);
    check({tag, "_lat"}, lat, lat_e);
    check({tag, "_shift"}, io.cfg_shift_o, sh_e);
    check({tag, "_mult"}, io.cfg_multiply_o, mul_e);
    check({tag, "_err"}, io.err_o, err_e);
    consume();
  endtask

  initial begin
    int lat;
    int seen;
    longint m_e;
    longint q;
    io.v_i = 1'b0;
    io.denom_i = '0;
    io.yumi_i = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", io.ready_o, 1);
    check("rst_v", io.v_o, 0);
    check("rst_mult", io.cfg_multiply_o, 0);
    check("rst_shift", io.cfg_shift_o, 0);
    check("rst_err", io.err_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    div_case("d3", 3, N+2, 2, 342, 0);
    div_case("d1", 1, N+2, 0, 256, 0);
    div_case("d7", 7, N+2, 3, 293, 0);
    div_case("d255", 255, N+2, 8, 258, 0);
    div_case("d0", 0, 1, 0, 0, 1);

    // yumi while idle must be ignored
    @(negedge clk);
    io.yumi_i = 1'b1;
    @(posedge clk);
    #1;
    io.yumi_i = 1'b0;
    check("idle_yumi_ready", io.ready_o, 1);
    check("idle_yumi_v", io.v_o, 0);

    // hold a result while v_i keeps pulsing
    run_div(W'(7), lat);
    check("hold_lat", lat, N+2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      io.v_i = k[0] ? 1'b0 : 1'b1;
      io.denom_i = W'(k + 2);
      @(posedge clk);
      #1;
      check("hold_v", io.v_o, 1);
      check("hold_ready", io.ready_o, 0);
      check("hold_mult", io.cfg_multiply_o, 293);
      check("hold_shift", io.cfg_shift_o, 3);
    end
    io.v_i = 1'b0;
    consume();

    // reset in the middle of a calculation
    @(negedge clk);
    io.v_i = 1'b1;
    io.denom_i = W'(7);
    @(posedge clk);
    #1;
    io.v_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", io.ready_o, 1);
    check("mid_rst_v", io.v_o, 0);
    check("mid_rst_mult", io.cfg_multiply_o, 0);
    check("mid_rst_shift", io.cfg_shift_o, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (io.v_o) seen = 1;
    end
    check("no_partial", seen, 0);
    div_case("d5", 5, N+2, 3, 410, 0);

    // every divisor, chained into a reciprocal divider
    for (int d = 1; d < 256; d++) begin
      run_div(W'(d), lat);
      m_e = ((64'd1 << (N + $clog2(d))) + d - 1) / d;
      check($sformatf("ex_lat_%0d", d), lat, N+2);
      check($sformatf("ex_shift_%0d", d), io.cfg_shift_o,
            $clog2(d));
      check($sformatf("ex_mult_%0d", d), io.cfg_multiply_o, m_e);
      for (int n = 0; n < 256; n++) begin
        q = (longint'(n) * longint'(io.cfg_multiply_o))
            >> (N + io.cfg_shift_o);
        check($sformatf("recip_d%0d_n%0d", d, n), q, n / d);
      end
      consume();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
